// File: rtl/dmem_pkg.sv
// Shared defaults, request/response shapes and index-width helper for the data-memory pipe.
package dmem_pkg;

    localparam int DMEM_DATA_W    = 32;
    localparam int DMEM_ADDR_W    = 16;
    localparam int DMEM_DEPTH     = 1024;
    localparam int DMEM_RD_LAT    = 2;
    localparam int DMEM_RSP_DEPTH = 4;

    typedef struct packed {
        logic                     we;
        logic [DMEM_ADDR_W-1:0]   addr;
        logic [DMEM_DATA_W-1:0]   wdata;
        logic [DMEM_DATA_W/8-1:0] be;
    } dmem_req_t;

    typedef struct packed {
        logic [DMEM_DATA_W-1:0] rdata;
        logic                   err;
    } dmem_rsp_t;

    // Index width that stays legal (>=1) for single-entry structures.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// In-order response buffer; push and pop may coincide, including when full.
module dmem_rsp_fifo
    import dmem_pkg::*;
#(
    parameter int  DEPTH = DMEM_RSP_DEPTH,
    parameter type T     = dmem_rsp_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int PW = idx_w(DEPTH);
    localparam int CW = idx_w(DEPTH + 1);

    T              store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Zero the head when empty so idle outputs read as all-zero.
    assign head    = empty ? T'('0) : store[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push != do_pop)
                count <= do_push ? count + CW'(1) : count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dmem_pipe.sv
// Byte-enabled data memory with a fixed-latency read pipeline and an ordered,
// backpressure-safe response buffer bounded by an outstanding-read count.
module dmem_pipe
    import dmem_pkg::*;
#(
    parameter int DATA_W    = DMEM_DATA_W,
    parameter int ADDR_W    = DMEM_ADDR_W,
    parameter int DEPTH     = DMEM_DEPTH,
    parameter int RD_LAT    = DMEM_RD_LAT,
    parameter int RSP_DEPTH = DMEM_RSP_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int NB     = DATA_W / 8;
    localparam int IW     = idx_w(DEPTH);
    localparam int OW     = idx_w(RSP_DEPTH + 1);
    localparam int STAGES = RD_LAT - 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [NB-1:0]     be;
    } req_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_t;

    if (DATA_W < 8 || (DATA_W % 8) != 0 || RD_LAT < 1 || RD_LAT > 4 ||
        RSP_DEPTH < RD_LAT || (DEPTH & (DEPTH - 1)) != 0 ||
        DEPTH > (2 ** ADDR_W)) begin : g_bad_cfg
        $error("dmem_pipe: illegal parameter combination");
    end

    req_t              req;
    logic              in_range;
    logic              accept;
    logic              rd_acc;
    logic              wr_acc;
    logic              pop;
    logic [OW-1:0]     outstanding;
    logic [DATA_W-1:0] mem [DEPTH];
    rsp_t              rd_rsp;
    logic [STAGES:0]   vld_pipe;
    rsp_t              dat_pipe [STAGES+1];
    rsp_t              head;
    logic              fifo_full;
    logic              fifo_empty;

    assign req = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

    assign in_range  = {1'b0, req.addr} < (ADDR_W + 1)'(DEPTH);
    assign req_ready = outstanding < OW'(RSP_DEPTH);
    assign accept    = rst_n & req_valid & req_ready;
    assign rd_acc    = accept & ~req.we;
    assign wr_acc    = accept & req.we & in_range;

    // Read is sampled at acceptance, so it sees every earlier write.
    assign rd_rsp = in_range ? rsp_t'{rdata: mem[req.addr[IW-1:0]], err: 1'b0}
                             : rsp_t'{rdata: '0, err: 1'b1};

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int b = 0; b < NB; b++)
                if (req.be[b]) mem[req.addr[IW-1:0]][b*8 +: 8] <= req.wdata[b*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_acc;
            for (int k = 1; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    always_ff @(posedge clk) begin
        dat_pipe[0] <= rd_rsp;
        for (int k = 1; k <= STAGES; k++) dat_pipe[k] <= dat_pipe[k-1];
    end

    assign pop = rsp_valid & rsp_ready;

    // Counts reads in the pipe plus the buffer, so the buffer can never overflow.
    always_ff @(posedge clk) begin
        if (!rst_n)
            outstanding <= '0;
        else if (rd_acc != pop)
            outstanding <= rd_acc ? outstanding + OW'(1) : outstanding - OW'(1);
    end

    dmem_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .T     (rsp_t)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vld_pipe[STAGES]),
        .push_data (dat_pipe[STAGES]),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst_n && vld_pipe[STAGES] && !pop) assert (!fifo_full);
    end

    assign rsp_valid = ~fifo_empty;
    assign rsp_rdata = head.rdata;
    assign rsp_err   = head.err;

endmodule

// File: tb/tb_dmem_pipe.sv
// Vector table, hand-written backpressure/reset sequences and a randomized run
// against a queue-and-array reference model of dmem_pipe.
module tb_dmem_pipe;
    import dmem_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int DEP = 1024;
    localparam int LAT = 2;
    localparam int RSD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [3:0]    req_be = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    dmem_pipe #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .DEPTH     (DEP),
        .RD_LAT    (LAT),
        .RSP_DEPTH (RSD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        dmem_req_t   req;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          t;
    } exp_t;

    int          nchk = 0;
    int          npass = 0;
    int          cyc = 0;
    vec_t        tbl[$];
    exp_t        q[$];
    logic [31:0] ref_mem [16];
    logic [15:0] sa [6] = '{16'd5, 16'd7, 16'd0, 16'd1023, 16'd5, 16'd7};
    logic [31:0] se [6] = '{32'hDE22BE44, 32'h00000077, 32'hFF345678,
                            32'hA5A5A5A5, 32'hDE22BE44, 32'h00000077};

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic w, input logic [15:0] a, input logic [31:0] d,
                                input logic [3:0] m, input logic [31:0] xd, input logic xe);
        vec_t v;
        v.req   = '{we: w, addr: a, wdata: d, be: m};
        v.rdata = xd;
        v.err   = xe;
        return v;
    endfunction

    // One request; reads wait (bounded) for their response and check latency and data.
    task automatic run_vec(input string nm, input vec_t v);
        int lat;
        req_valid = 1'b1;
        req_we    = v.req.we;
        req_addr  = v.req.addr;
        req_wdata = v.req.wdata;
        req_be    = v.req.be;
        chk({nm, "/ready"}, 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        if (!v.req.we) begin
            lat = 0;
            while (!rsp_valid && lat < 10) begin
                step();
                lat++;
            end
            chk({nm, "/lat"}, 64'(lat), 64'(LAT));
            chk({nm, "/rdata"}, 64'(rsp_rdata), 64'(v.rdata));
            chk({nm, "/err"}, 64'(rsp_err), 64'(v.err));
            step();
        end
    endtask

    initial begin
        int          acc;
        int          got;
        logic        hold;
        logic [63:0] held;

        // Reset with a read pending on the inputs: it must be ignored.
        rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 16'd5;
        step(); step(); step();
        rst_n = 1'b1; req_valid = 1'b0;
        chk("reset/rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset/rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("reset/rsp_err", 64'(rsp_err), 64'd0);
        chk("reset/req_ready", 64'(req_ready), 64'd1);
        step(); step(); step();
        chk("reset/no_ghost", 64'(rsp_valid), 64'd0);

        tbl.push_back(mk(1'b1, 16'd5,     32'hDEADBEEF, 4'hF, 32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 16'd5,     32'h0,        4'h0, 32'hDEADBEEF, 1'b0));
        tbl.push_back(mk(1'b1, 16'd5,     32'h11223344, 4'h5, 32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 16'd5,     32'h0,        4'h0, 32'hDE22BE44, 1'b0));
        tbl.push_back(mk(1'b1, 16'd7,     32'h00000077, 4'hF, 32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 16'd7,     32'h0,        4'h0, 32'h00000077, 1'b0));
        tbl.push_back(mk(1'b1, 16'd0,     32'h12345678, 4'hF, 32'h0,        1'b0));
        tbl.push_back(mk(1'b1, 16'd0,     32'hFFFFFFFF, 4'h8, 32'h0,        1'b0));
        tbl.push_back(mk(1'b1, 16'd1024,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 16'd1024,  32'h0,        4'h0, 32'h0,        1'b1));
        tbl.push_back(mk(1'b0, 16'd0,     32'h0,        4'h0, 32'hFF345678, 1'b0));
        tbl.push_back(mk(1'b1, 16'd1023,  32'hA5A5A5A5, 4'hF, 32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 16'd1023,  32'h0,        4'h0, 32'hA5A5A5A5, 1'b0));
        tbl.push_back(mk(1'b0, 16'hFFFF,  32'h0,        4'h0, 32'h0,        1'b1));
        tbl.push_back(mk(1'b1, 16'd5,     32'h00000000, 4'h0, 32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 16'd5,     32'h0,        4'h0, 32'hDE22BE44, 1'b0));
        foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Six back-to-back reads with the consumer stalled, then released.
        rsp_ready = 1'b0;
        acc = 0;
        got = 0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            if (c == 10) rsp_ready = 1'b1;
            req_valid = (acc < 6);
            req_we    = 1'b0;
            req_be    = 4'hF;
            req_addr  = (acc < 6) ? sa[acc] : 16'd0;
            if (c == 3) chk("bp/ready_before_full", 64'(req_ready), 64'd1);
            if (c == 4) begin
                chk("bp/accepted4", 64'(acc), 64'd4);
                chk("bp/ready_full", 64'(req_ready), 64'd0);
            end
            if (c == 8) begin
                chk("bp/still_full", 64'(req_ready), 64'd0);
                chk("bp/head_valid", 64'(rsp_valid), 64'd1);
                chk("bp/head_data", 64'(rsp_rdata), 64'(se[0]));
            end
            if (rsp_valid && rsp_ready) begin
                chk($sformatf("bp/rsp%0d", got), 64'(rsp_rdata), 64'(se[got]));
                got++;
            end
            if (req_valid && req_ready) acc++;
            step();
        end
        req_valid = 1'b0;
        chk("bp/got6", 64'(got), 64'd6);

        // Three reads in flight, then a one-edge reset carrying a write that must be ignored.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = sa[i];
            step();
        end
        req_we = 1'b1; req_addr = 16'd5; req_wdata = 32'h0; req_be = 4'hF;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        chk("rst/req_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("rst/no_rsp", 64'(rsp_valid), 64'd0);
            step();
        end
        run_vec("rst/reread", mk(1'b0, 16'd5, 32'h0, 4'h0, 32'hDE22BE44, 1'b0));

        // Randomized traffic against the reference model.
        hold = 1'b0;
        held = '0;
        for (int c = 0; c < 2000; c++) begin
            exp_t e;
            if (c < 16) begin
                req_valid = 1'b1; req_we = 1'b1; req_addr = 16'(c);
                req_wdata = $urandom; req_be = 4'hF; rsp_ready = 1'b1;
            end else if (c < 1900) begin
                req_valid = ($urandom_range(0, 9) < 7);
                req_we    = ($urandom_range(0, 9) < 4);
                req_addr  = ($urandom_range(0, 7) == 0) ? 16'(1024 + $urandom_range(0, 64511))
                                                        : 16'($urandom_range(0, 15));
                req_wdata = $urandom;
                req_be    = 4'($urandom);
                rsp_ready = ($urandom_range(0, 9) < 6);
            end else begin
                req_valid = 1'b0;
                rsp_ready = 1'b1;
            end
            chk("rnd/req_ready", 64'(req_ready), 64'(q.size() < RSD));
            chk("rnd/rsp_valid", 64'(rsp_valid), 64'(q.size() > 0 && q[0].t + LAT <= cyc));
            if (hold) chk("rnd/hold", {29'd0, rsp_valid, rsp_err, rsp_rdata}, held);
            if (rsp_valid && rsp_ready && q.size() > 0) begin
                chk("rnd/rdata", 64'(rsp_rdata), 64'(q[0].d));
                chk("rnd/err", 64'(rsp_err), 64'(q[0].e));
                void'(q.pop_front());
            end
            hold = rsp_valid && !rsp_ready;
            held = {29'd0, rsp_valid, rsp_err, rsp_rdata};
            if (req_valid && req_ready) begin
                if (req_we) begin
                    if (req_addr < 16'(DEP)) begin
                        for (int b = 0; b < 4; b++)
                            if (req_be[b]) ref_mem[req_addr[3:0]][b*8 +: 8] = req_wdata[b*8 +: 8];
                    end
                end else begin
                    e.t = cyc + 1;
                    e.e = !(req_addr < 16'(DEP));
                    e.d = e.e ? 32'h0 : ref_mem[req_addr[3:0]];
                    q.push_back(e);
                end
            end
            step();
        end
        chk("rnd/drained", 64'(q.size()), 64'd0);
        chk("rnd/idle", 64'(rsp_valid), 64'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
